// File: rtl/sumi3_pkg.sv
// Shared types for the sumi3 launch front end: FSM state encoding and the
// (x, n) argument pair carried through the argument FIFO.
package sumi3_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN
  } launch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] n;
  } sumi3_args_t;

endpackage

// File: rtl/sumi3_launcher_if.sv
// Bundles the host argument/result streams and the graph start/end channels
// that the launcher sits between.
interface sumi3_launcher_if #(
  parameter int DATA_W = sumi3_pkg::DATA_W,
  parameter int TAG_W  = 4
);

  logic [DATA_W-1:0] arg_x_in;
  logic [DATA_W-1:0] arg_n_in;
  logic              arg_valid;
  logic              arg_ready;

  logic [DATA_W-1:0] x_dout;
  logic [DATA_W-1:0] n_dout;
  logic              start_out;
  logic              start_valid;
  logic              start_ready;

  logic [DATA_W-1:0] end_in;
  logic              end_valid_in;
  logic              end_ready_out;

  logic [DATA_W-1:0] res_out;
  logic [TAG_W-1:0]  res_tag;
  logic              res_valid;
  logic              res_ready;

  logic              busy;
  logic              timeout_err;

  // Launcher side.
  modport master (
    input  arg_x_in, arg_n_in, arg_valid,
    output arg_ready,
    output x_dout, n_dout, start_out, start_valid,
    input  start_ready,
    input  end_in, end_valid_in,
    output end_ready_out,
    output res_out, res_tag, res_valid,
    input  res_ready,
    output busy, timeout_err
  );

  // Host and graph side.
  modport slave (
    output arg_x_in, arg_n_in, arg_valid,
    input  arg_ready,
    input  x_dout, n_dout, start_out, start_valid,
    output start_ready,
    output end_in, end_valid_in,
    input  end_ready_out,
    input  res_out, res_tag, res_valid,
    output res_ready,
    input  busy, timeout_err
  );

endinterface

// File: rtl/sumi3_arg_fifo.sv
// Small argument FIFO; head is read combinationally so IDLE can pop and
// register the pair in the same cycle it sees the FIFO non-empty.
module sumi3_arg_fifo #(
  parameter int  DEPTH  = 4,
  parameter type elem_t = sumi3_pkg::sumi3_args_t
) (
  input  logic  clk,
  input  logic  rst_ni,
  input  logic  push_i,
  input  elem_t din_i,
  output logic  full_o,
  input  logic  pop_i,
  output elem_t dout_o,
  output logic  empty_o
);

  import sumi3_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  elem_t mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  // Same index with differing wrap bit means the writer has lapped the reader.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = wr_ptr_q + PW'(do_push);
  assign rd_ptr_d = rd_ptr_q + PW'(do_pop);

  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/sumi3_launcher.sv
// Issue stage for sumi3_graph: buffers host (x, n) pairs, launches one graph
// execution at a time and returns each result tagged with its launch number.
module sumi3_launcher #(
  parameter int DATA_W  = sumi3_pkg::DATA_W,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  sumi3_launcher_if.master   bus
);

  import sumi3_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] n;
  } args_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  launch_state_t     state_q, state_d;

  args_t             fifo_din;
  args_t             fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  launch_tag_q, launch_tag_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              launch_valid;
  logic              end_ready;

  assign fifo_din  = '{x: bus.arg_x_in, n: bus.arg_n_in};
  assign fifo_push = bus.arg_valid && !fifo_full;

  sumi3_arg_fifo #(
    .DEPTH  (DEPTH),
    .elem_t (args_t)
  ) u_arg_fifo (
    .clk     (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    n_d          = n_q;
    tag_d        = tag_q;
    launch_tag_d = launch_tag_q;
    res_d        = res_q;
    res_tag_d    = res_tag_q;
    res_valid_d  = res_valid_q;
    fifo_pop     = 1'b0;
    launch_valid = 1'b0;
    end_ready    = 1'b0;

    if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          x_d      = fifo_head.x;
          n_d      = fifo_head.n;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        launch_valid = 1'b1;
        if (bus.start_ready) begin
          launch_tag_d = tag_q;
          tag_d        = tag_q + TAG_W'(1);
          state_d      = RUN;
        end
      end
      RUN: begin
        // A pending result that the host is draining this cycle frees the slot.
        end_ready = !res_valid_q || bus.res_ready;
        if (bus.end_valid_in && end_ready) begin
          res_d       = bus.end_in;
          res_tag_d   = launch_tag_q;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Hang watchdog: only flags, never aborts the launch in progress.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (state_q != IDLE) begin
      cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      n_q          <= '0;
      tag_q        <= '0;
      launch_tag_q <= '0;
      res_q        <= '0;
      res_tag_q    <= '0;
      res_valid_q  <= 1'b0;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      n_q          <= n_d;
      tag_q        <= tag_d;
      launch_tag_q <= launch_tag_d;
      res_q        <= res_d;
      res_tag_q    <= res_tag_d;
      res_valid_q  <= res_valid_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.arg_ready     = !fifo_full;
  assign bus.x_dout        = x_q;
  assign bus.n_dout        = n_q;
  assign bus.start_valid   = launch_valid;
  assign bus.start_out     = launch_valid;
  assign bus.end_ready_out = end_ready;
  assign bus.res_out       = res_q;
  assign bus.res_tag       = res_tag_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.timeout_err   = timeout_q;

endmodule

// File: tb/tb_sumi3_launcher.sv
// Scoreboard bench for sumi3_launcher with a behavioural x**n graph model.
module tb_sumi3_launcher;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int TAG_W     = 2;
  localparam int TIMEOUT   = 16;
  localparam int GRAPH_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sumi3_launcher_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  sumi3_launcher #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]      val;
    logic [TAG_W-1:0] tag;
  } res_exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] n;
  } start_exp_t;

  res_exp_t   exp_res_q[$];
  start_exp_t exp_start_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int launch_no = 0;
  bit start_en   = 1'b0;
  bit graph_hang = 1'b0;

  logic [31:0] wrap_res [5] = '{32'd1, 32'd3, 32'd9, 32'd27, 32'd81};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
  endtask

  function automatic logic [31:0] ipow(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned k = 0; k < e; k++) r = r * b;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    exp_res_q.delete();
    exp_start_q.delete();
    launch_no = 0;
  endtask

  task automatic expect_launch(input logic [31:0] x, input logic [31:0] n,
                               input logic [31:0] res, input bit has_res);
    exp_start_q.push_back('{x: x, n: n});
    if (has_res) exp_res_q.push_back('{val: res, tag: TAG_W'(launch_no)});
    launch_no++;
  endtask

  task automatic push_arg(input logic [31:0] x, input logic [31:0] n);
    bit ok;
    ok = 1'b0;
    bus.arg_x_in  = x;
    bus.arg_n_in  = n;
    bus.arg_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.arg_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    bus.arg_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL push_accept: arg_ready 0 for 200 cycles, required 1");
    end
  endtask

  task automatic wait_drain(input string name, input int bound);
    int i;
    i = 0;
    while ((exp_res_q.size() != 0 || exp_start_q.size() != 0) && i < bound) begin
      @(negedge clk);
      i++;
    end
    n_checks++;
    if (exp_res_q.size() == 0 && exp_start_q.size() == 0) n_pass++;
    else $display("FAIL %s: %0d results and %0d launches outstanding, required 0",
                  name, exp_res_q.size(), exp_start_q.size());
    tick();
  endtask

  // Behavioural graph: accepts a start, computes x**n after GRAPH_LAT cycles,
  // then holds end_valid until the launcher takes it.
  initial begin : graph_model
    bit          s_fire, e_fire, in_rst;
    int          g_state, g_cnt;
    logic [31:0] g_x, g_n;
    g_state = 0;
    g_cnt   = 0;
    g_x     = '0;
    g_n     = '0;
    bus.start_ready  = 1'b0;
    bus.end_valid_in = 1'b0;
    bus.end_in       = '0;
    forever begin
      @(negedge clk);
      in_rst = !rst;
      s_fire = bus.start_valid && bus.start_ready;
      e_fire = bus.end_valid_in && bus.end_ready_out;
      if (s_fire) begin
        g_x = bus.x_dout;
        g_n = bus.n_dout;
      end
      tick();
      if (in_rst) g_state = 0;
      else begin
        case (g_state)
          0: if (s_fire) begin
               g_state = 1;
               g_cnt   = GRAPH_LAT;
             end
          1: begin
               g_cnt--;
               if (g_cnt <= 0 && !graph_hang) g_state = 2;
             end
          default: if (e_fire) g_state = 0;
        endcase
      end
      bus.start_ready  = (g_state == 0) && start_en;
      bus.end_valid_in = (g_state == 2);
      bus.end_in       = (g_state == 2) ? ipow(g_x, g_n) : 32'd0;
    end
  end

  initial begin : monitor
    start_exp_t se;
    res_exp_t   re;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.start_valid && bus.start_ready) begin
          if (exp_start_q.size() == 0) begin
            n_checks++;
            $display("FAIL start_unexpected: launch x=%0d n=%0d, required none",
                     bus.x_dout, bus.n_dout);
          end else begin
            se = exp_start_q.pop_front();
            $display("launch x=%0d n=%0d", bus.x_dout, bus.n_dout);
            check("start_x", 64'(bus.x_dout), 64'(se.x));
            check("start_n", 64'(bus.n_dout), 64'(se.n));
            check("start_out", 64'(bus.start_out), 64'd1);
          end
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_res_q.size() == 0) begin
            n_checks++;
            $display("FAIL res_unexpected: result %0d tag %0d, required none",
                     bus.res_out, bus.res_tag);
          end else begin
            re = exp_res_q.pop_front();
            $display("result %0d tag %0d", bus.res_out, bus.res_tag);
            check("res_value", 64'(bus.res_out), 64'(re.val));
            check("res_tag", 64'(bus.res_tag), 64'(re.tag));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit ok;
    bit bad;
    bus.arg_x_in  = '0;
    bus.arg_n_in  = '0;
    bus.arg_valid = 1'b0;
    bus.res_ready = 1'b0;

    // Reset state and basic launch 2**3.
    do_reset();
    @(negedge clk);
    check("rst_arg_ready", 64'(bus.arg_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_start_valid", 64'(bus.start_valid), 64'd0);
    check("rst_timeout", 64'(bus.timeout_err), 64'd0);
    check("rst_x_dout", 64'(bus.x_dout), 64'd0);
    tick();
    bus.res_ready = 1'b1;
    start_en = 1'b1;
    tick();
    expect_launch(32'd2, 32'd3, 32'd8, 1'b1);
    push_arg(32'd2, 32'd3);
    @(negedge clk);
    check("lat_t1_start_valid", 64'(bus.start_valid), 64'd0);
    @(negedge clk);
    check("lat_t2_start_valid", 64'(bus.start_valid), 64'd1);
    @(negedge clk);
    check("run_busy", 64'(bus.busy), 64'd1);
    check("run_start_valid", 64'(bus.start_valid), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.res_valid) break;
      if (bus.x_dout != 32'd2 || bus.n_dout != 32'd3) bad = 1'b1;
      @(negedge clk);
    end
    check("args_held_in_run", 64'(bad), 64'd0);
    wait_drain("basic_drain", 50);

    // FIFO full: one pair in LAUNCH, four buffered, sixth offer refused.
    start_en = 1'b0;
    do_reset();
    tick();
    expect_launch(32'd1, 32'd1, 32'd1, 1'b1);
    expect_launch(32'd2, 32'd2, 32'd4, 1'b1);
    expect_launch(32'd3, 32'd2, 32'd9, 1'b1);
    expect_launch(32'd2, 32'd4, 32'd16, 1'b1);
    expect_launch(32'd4, 32'd3, 32'd64, 1'b1);
    push_arg(32'd1, 32'd1);
    push_arg(32'd2, 32'd2);
    push_arg(32'd3, 32'd2);
    push_arg(32'd2, 32'd4);
    push_arg(32'd4, 32'd3);
    bus.arg_x_in  = 32'd9;
    bus.arg_n_in  = 32'd9;
    bus.arg_valid = 1'b1;
    @(negedge clk);
    check("full_arg_ready", 64'(bus.arg_ready), 64'd0);
    tick();
    @(negedge clk);
    check("full_arg_ready_hold", 64'(bus.arg_ready), 64'd0);
    check("full_start_waiting", 64'(bus.start_valid), 64'd1);
    tick();
    bus.arg_valid = 1'b0;
    start_en = 1'b1;
    wait_drain("fifo_full_drain", 300);
    repeat (10) @(negedge clk);
    check("full_idle_after", 64'(bus.busy), 64'd0);
    tick();

    // Host backpressure: second result must wait in the graph.
    do_reset();
    bus.res_ready = 1'b0;
    tick();
    expect_launch(32'd3, 32'd1, 32'd3, 1'b1);
    expect_launch(32'd2, 32'd5, 32'd32, 1'b1);
    push_arg(32'd3, 32'd1);
    push_arg(32'd2, 32'd5);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.res_valid && bus.end_valid_in && bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("bp_second_end_seen", 64'(ok), 64'd1);
    check("bp_end_ready", 64'(bus.end_ready_out), 64'd0);
    repeat (3) @(negedge clk);
    check("bp_end_valid_held", 64'(bus.end_valid_in), 64'd1);
    check("bp_end_ready_hold", 64'(bus.end_ready_out), 64'd0);
    check("bp_pending_res", 64'(bus.res_out), 64'd3);
    check("bp_pending_tag", 64'(bus.res_tag), 64'd0);
    tick();
    bus.res_ready = 1'b1;
    wait_drain("backpressure_drain", 60);

    // Tag wrap with a 2-bit tag: 3**0 .. 3**4.
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) expect_launch(32'd3, 32'(i), wrap_res[i], 1'b1);
    for (int i = 0; i < 5; i++) push_arg(32'd3, 32'(i));
    wait_drain("tag_wrap_drain", 300);

    // Timeout with a graph that never ends.
    graph_hang = 1'b1;
    do_reset();
    tick();
    expect_launch(32'd7, 32'd2, 32'd49, 1'b0);
    push_arg(32'd7, 32'd2);
    @(negedge clk);
    repeat (16) @(negedge clk);
    check("timeout_before", 64'(bus.timeout_err), 64'd0);
    @(negedge clk);
    check("timeout_at_16", 64'(bus.timeout_err), 64'd1);
    repeat (5) @(negedge clk);
    check("timeout_sticky", 64'(bus.timeout_err), 64'd1);
    check("timeout_still_busy", 64'(bus.busy), 64'd1);
    do_reset();
    graph_hang = 1'b0;
    @(negedge clk);
    check("timeout_cleared", 64'(bus.timeout_err), 64'd0);
    tick();

    // Reset in the middle of RUN, then a clean launch 5**2.
    expect_launch(32'd4, 32'd3, 32'd64, 1'b0);
    push_arg(32'd4, 32'd3);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy && !bus.start_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("mr_reached_run", 64'(ok), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_res_q.delete();
    exp_start_q.delete();
    launch_no = 0;
    @(negedge clk);
    check("mr_busy", 64'(bus.busy), 64'd0);
    check("mr_res_valid", 64'(bus.res_valid), 64'd0);
    check("mr_arg_ready", 64'(bus.arg_ready), 64'd1);
    tick();
    expect_launch(32'd5, 32'd2, 32'd25, 1'b1);
    push_arg(32'd5, 32'd2);
    wait_drain("mid_reset_drain", 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sumi3_launcher.md
Name: sumi3_launcher

Overview:
- Upstream issue stage for sumi3_graph, the dynamically scheduled x**n datapath.
- Accepts (x, n) argument pairs from a host valid/ready stream and buffers them in a small FIFO.
- Issues exactly one start token at a time to the graph, holding x_din/n_din stable for the whole execution.
- Consumes the graph's end channel and returns each result to the host, tagged with a wrapping launch sequence number.

Parameters:
- DATA_W, 32, width of x, n and result.
- DEPTH, 4, argument FIFO entries; power of 2, minimum 2.
- TAG_W, 4, width of the launch sequence tag.
- TIMEOUT, 1024, cycles allowed in LAUNCH+RUN before timeout_err sets.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low: rst==0 at a posedge resets the block.
- arg_x_in  in  DATA_W  host x.
- arg_n_in  in  DATA_W  host n.
- arg_valid  in  1  host argument valid.
- arg_ready  out  1  FIFO can accept.
- x_dout  out  DATA_W  to graph x_din.
- n_dout  out  DATA_W  to graph n_din.
- start_out  out  1  start token value; constant 1 while start_valid.
- start_valid  out  1  to graph start_valid.
- start_ready  in  1  from graph start_ready.
- end_in  in  DATA_W  graph end_out.
- end_valid_in  in  1  graph end_valid.
- end_ready_out  out  1  to graph end_ready.
- res_out  out  DATA_W  result to host.
- res_tag  out  TAG_W  launch tag of res_out.
- res_valid  out  1  result valid.
- res_ready  in  1  host accepts result.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  sticky hang flag.

Behaviour:
- Reset (rst==0 at a posedge):
  - FIFO empties.
  - FSM goes to IDLE.
  - Tag counter, timeout counter and all outputs go to 0, including timeout_err and res_valid.
  - arg_ready reads 1 from the first cycle after reset deasserts.
  - Reset mid-operation abandons the in-flight launch without a handshake. The bench resets the graph together with this block.
- FIFO:
  - arg_ready = !full. A push occurs when arg_valid && arg_ready.
  - Pop and push may coincide when the FIFO is not full; occupancy is then unchanged.
  - Pointers wrap modulo DEPTH. The full/empty distinction uses an extra pointer bit.
- FSM states are IDLE, LAUNCH and RUN.
  - IDLE: if the FIFO is non-empty, pop the head into the x_dout/n_dout registers, then go to LAUNCH next cycle.
  - LAUNCH:
    - start_valid=1 and start_out=1.
    - On start_valid && start_ready, go to RUN and increment the tag counter. The launch keeps the pre-increment tag.
  - RUN:
    - start_valid=0.
    - x_dout and n_dout stay held; they change only on a pop in IDLE.
    - end_ready_out = !res_valid || res_ready.
    - On end_valid_in && end_ready_out, capture end_in and the launch tag into the result register, set res_valid, and go to IDLE.
- Latency: an argument pushed at cycle t reaches start_valid=1 at t+2 at the earliest. Back-to-back launches are separated by at least 1 IDLE cycle.
- Result register:
  - res_valid stays high until res_valid && res_ready.
  - A capture and a drain in the same cycle loads the new value.
  - A new launch may proceed while a result is pending.
- Timeout:
  - The counter increments every cycle in LAUNCH or RUN and clears in IDLE.
  - When it reaches TIMEOUT, timeout_err is set (sticky until reset). The FSM keeps waiting and is not aborted.
- The tag wraps modulo 2**TAG_W.
- Arithmetic is unsigned. x and n pass through without modification.

Decomposition:
- Package sumi3_pkg holds:
  - the DATA_W default;
  - typedef enum logic [1:0] {IDLE, LAUNCH, RUN} launch_state_t;
  - typedef struct packed { logic [DATA_W-1:0] x, n; } sumi3_args_t.
- One sub-module, sumi3_arg_fifo: a parameterised DEPTH FIFO of sumi3_args_t with push/pop/full/empty.

Test Plan:
- Basic launch: push x=2, n=3 with the real sumi3_graph → start_valid pulse with x_dout=2 and n_dout=3; res_out=8 with res_tag=0. x_dout stays 2 until the result.
- FIFO full: hold start_ready=0 and offer 5 pairs with DEPTH=4 → 1 pair is popped into LAUNCH, 4 are buffered, and the 6th offer sees arg_ready=0. Release start_ready → 5 results return in order with tags 0..4.
- Host backpressure: res_ready=0 while 2 launches complete → end_ready_out=0 during the second RUN and the graph holds end_valid. Raise res_ready → both results arrive in order, none lost.
- Tag wrap: TAG_W=2, 5 launches (x=3, n=i for i=0..4) → results 1, 3, 9, 27, 81 with tags 0, 1, 2, 3, 0.
- Timeout: TIMEOUT=16 with a behavioural graph that never asserts end_valid → timeout_err=1 exactly 16 cycles after entering LAUNCH; it stays set until rst=0.
- Reset mid-RUN: assert rst=0 for 1 cycle during RUN → next cycle has busy=0, res_valid=0, arg_ready=1. A following x=5, n=2 launch returns 25 with tag 0.
